// File: rtl/pspin_cfg_pkg.sv
// Shared PsPIN sizing constants and command/completion record types.
// Command slots are addressed by the packed {cluster_id, core_id, local_cmd_id} tuple.
package pspin_cfg_pkg;

   localparam int NUM_CLUSTERS       = 4;
   localparam int NUM_CORES          = 8;
   localparam int NUM_HPU_CMDS       = 4;
   localparam int NUM_CMD_INTERFACES = 3;

   localparam int CMD_SLOTS = NUM_CLUSTERS * NUM_CORES * NUM_HPU_CMDS;
   localparam int SLOT_W    = $clog2(CMD_SLOTS);

   typedef struct packed {
      logic [1:0] cluster_id;
      logic [2:0] core_id;
      logic [1:0] local_cmd_id;
   } pspin_cmd_id_t;

   typedef struct packed {
      pspin_cmd_id_t cmd_id;
      logic          generate_event;
      logic [1:0]    intf_id;
      logic [31:0]   cmd_data;
   } pspin_cmd_t;

   typedef struct packed {
      pspin_cmd_id_t cmd_id;
      logic [31:0]   resp_data;
   } pspin_cmd_resp_t;

   function automatic logic [SLOT_W-1:0] cmd_slot(pspin_cmd_id_t id);
      return {id.cluster_id, id.core_id, id.local_cmd_id};
   endfunction

endpackage

// File: rtl/rr_arb_idx.sv
// Round-robin arbiter returning a grant index; the search starts at ptr_q,
// which moves to one past the winner only when the grant is accepted.
module rr_arb_idx #(
   parameter  int N     = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N-1:0]     req_i,
   input  logic             advance_i,
   output logic             gnt_valid_o,
   output logic [IDX_W-1:0] gnt_idx_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;

   function automatic logic [IDX_W-1:0] wrap_idx(int base, int off);
      int s;
      s = base + off;
      if (s >= N) s = s - N;
      return IDX_W'(s);
   endfunction

   // Walk from the farthest offset down so the nearest requester wins.
   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      for (int off = N - 1; off >= 0; off--) begin
         if (req_i[wrap_idx(int'(ptr_q), off)]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = wrap_idx(int'(ptr_q), off);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i && gnt_valid_o) ptr_d = wrap_idx(int'(gnt_idx_o), 1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/pspin_cmd_router.sv
// Routes cluster commands to downstream command interfaces and returns their
// completions, tracking every outstanding cmd_id in a pending table.
module pspin_cmd_router
   import pspin_cfg_pkg::*;
#(
   parameter int NUM_REQS = pspin_cfg_pkg::NUM_CLUSTERS,
   parameter int NUM_INTF = pspin_cfg_pkg::NUM_CMD_INTERFACES
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic            [NUM_REQS-1:0]   cmd_req_valid_i,
   output logic            [NUM_REQS-1:0]   cmd_req_ready_o,
   input  pspin_cmd_t      [NUM_REQS-1:0]   cmd_req_i,
   output logic            [NUM_INTF-1:0]   intf_cmd_valid_o,
   input  logic            [NUM_INTF-1:0]   intf_cmd_ready_i,
   output pspin_cmd_t                       intf_cmd_o,
   input  logic            [NUM_INTF-1:0]   intf_resp_valid_i,
   output logic            [NUM_INTF-1:0]   intf_resp_ready_o,
   input  pspin_cmd_resp_t [NUM_INTF-1:0]   intf_resp_i,
   output logic            [NUM_REQS-1:0]   cmd_resp_valid_o,
   output pspin_cmd_resp_t                  cmd_resp_o,
   output logic            [7:0]            inflight_o,
   output logic                             err_o
);

   localparam int REQ_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
   localparam int INTF_W = (NUM_INTF > 1) ? $clog2(NUM_INTF) : 1;

   logic                  cmd_valid_q, cmd_valid_d;
   pspin_cmd_t            cmd_q, cmd_d;
   logic                  rsp_valid_q, rsp_valid_d;
   pspin_cmd_resp_t       rsp_q, rsp_d;
   logic [CMD_SLOTS-1:0]  pend_q, pend_d;
   logic [CMD_SLOTS-1:0]  gen_q, gen_d;
   logic [7:0]            inflight_q, inflight_d;
   logic                  err_q, err_d;

   logic [NUM_REQS-1:0]   req_mask;
   logic                  req_gnt_valid;
   logic [REQ_W-1:0]      req_gnt_idx;
   logic                  rsp_gnt_valid;
   logic [INTF_W-1:0]     rsp_gnt_idx;
   logic                  cmd_handoff;
   logic                  cmd_can_accept;
   logic                  cmd_fire;
   logic                  cmd_bad;
   logic                  rsp_fire;
   pspin_cmd_t            cmd_sel;
   pspin_cmd_resp_t       rsp_sel;
   logic [SLOT_W-1:0]     cmd_sel_slot;
   logic [SLOT_W-1:0]     rsp_sel_slot;

   // Masking uses pend_q, so a slot freed this cycle is only grantable next cycle.
   always_comb begin
      req_mask = '0;
      for (int r = 0; r < NUM_REQS; r++)
         req_mask[r] = cmd_req_valid_i[r] & ~pend_q[cmd_slot(cmd_req_i[r].cmd_id)];
   end

   rr_arb_idx #(.N(NUM_REQS)) u_req_arb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (req_mask),
      .advance_i   (cmd_fire),
      .gnt_valid_o (req_gnt_valid),
      .gnt_idx_o   (req_gnt_idx)
   );

   rr_arb_idx #(.N(NUM_INTF)) u_rsp_arb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (intf_resp_valid_i),
      .advance_i   (rsp_fire),
      .gnt_valid_o (rsp_gnt_valid),
      .gnt_idx_o   (rsp_gnt_idx)
   );

   always_comb begin
      intf_cmd_valid_o = '0;
      for (int i = 0; i < NUM_INTF; i++)
         if (cmd_valid_q && (int'(cmd_q.intf_id) == i)) intf_cmd_valid_o[i] = 1'b1;
   end

   always_comb begin
      cmd_resp_valid_o = '0;
      for (int r = 0; r < NUM_REQS; r++)
         if (rsp_valid_q && (int'(rsp_q.cmd_id.cluster_id) == r)) cmd_resp_valid_o[r] = 1'b1;
   end

   // Both handshakes are gated by rst_ni so nothing is accepted while in reset.
   assign cmd_handoff    = |(intf_cmd_valid_o & intf_cmd_ready_i);
   assign cmd_can_accept = rst_ni & (~cmd_valid_q | cmd_handoff);
   assign cmd_fire       = req_gnt_valid & cmd_can_accept;
   assign cmd_sel        = cmd_req_i[req_gnt_idx];
   assign cmd_sel_slot   = cmd_slot(cmd_sel.cmd_id);
   assign cmd_bad        = int'(cmd_sel.intf_id) >= NUM_INTF;
   assign rsp_fire       = rsp_gnt_valid & rst_ni;
   assign rsp_sel        = intf_resp_i[rsp_gnt_idx];
   assign rsp_sel_slot   = cmd_slot(rsp_sel.cmd_id);

   always_comb begin
      cmd_req_ready_o = '0;
      if (cmd_fire) cmd_req_ready_o[req_gnt_idx] = 1'b1;
   end

   always_comb begin
      intf_resp_ready_o = '0;
      if (rsp_fire) intf_resp_ready_o[rsp_gnt_idx] = 1'b1;
   end

   always_comb begin
      cmd_valid_d = cmd_valid_q;
      cmd_d       = cmd_q;
      rsp_valid_d = 1'b0;
      rsp_d       = rsp_q;
      pend_d      = pend_q;
      gen_d       = gen_q;
      inflight_d  = inflight_q;
      err_d       = 1'b0;

      if (cmd_handoff) cmd_valid_d = 1'b0;

      if (cmd_fire) begin
         if (cmd_bad) begin
            err_d = 1'b1;
         end else begin
            cmd_valid_d          = 1'b1;
            cmd_d                = cmd_sel;
            pend_d[cmd_sel_slot] = 1'b1;
            gen_d[cmd_sel_slot]  = cmd_sel.generate_event;
            inflight_d           = inflight_d + 8'd1;
         end
      end

      // The arbiter mask guarantees this never clears the slot just set above.
      if (rsp_fire) begin
         if (pend_q[rsp_sel_slot]) begin
            pend_d[rsp_sel_slot] = 1'b0;
            inflight_d           = inflight_d - 8'd1;
            if (gen_q[rsp_sel_slot]) begin
               rsp_valid_d = 1'b1;
               rsp_d       = rsp_sel;
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cmd_valid_q <= 1'b0;
         cmd_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
         pend_q      <= '0;
         gen_q       <= '0;
         inflight_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         cmd_valid_q <= cmd_valid_d;
         cmd_q       <= cmd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
         pend_q      <= pend_d;
         gen_q       <= gen_d;
         inflight_q  <= inflight_d;
         err_q       <= err_d;
      end
   end

   assign intf_cmd_o = cmd_q;
   assign cmd_resp_o = rsp_q;
   assign inflight_o = inflight_q;
   assign err_o      = err_q;

endmodule

// File: doc/pspin_cmd_router.md
PSPIN_CMD_ROUTER -- requirements
Module: pspin_cmd_router

Interface
REQ-001 Parameter NUM_REQS, default pspin_cfg_pkg::NUM_CLUSTERS (4), number of command requesters (one per cluster).
REQ-002 Parameter NUM_INTF, default pspin_cfg_pkg::NUM_CMD_INTERFACES (3), number of downstream command interfaces.
REQ-003 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk_i  in  1  clock.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 cmd_req_valid_i  in  NUM_REQS  per-requester command valid.
REQ-007 cmd_req_ready_o  out  NUM_REQS  per-requester command accept.
REQ-008 cmd_req_i  in  NUM_REQS x pspin_cmd_t  commands.
REQ-009 intf_cmd_valid_o  out  NUM_INTF  command valid, one-hot by intf_id.
REQ-010 intf_cmd_ready_i  in  NUM_INTF  interface accept.
REQ-011 intf_cmd_o  out  pspin_cmd_t  command bus shared by all interfaces.
REQ-012 intf_resp_valid_i / intf_resp_ready_o  in/out  NUM_INTF  completion handshake.
REQ-013 intf_resp_i  in  NUM_INTF x pspin_cmd_resp_t  completions.
REQ-014 cmd_resp_valid_o  out  NUM_REQS  completion valid, one-hot by cmd_id.cluster_id.
REQ-015 cmd_resp_o  out  pspin_cmd_resp_t  completion bus shared by all requesters.
REQ-016 inflight_o  out  8  number of pending commands.
REQ-017 err_o  out  1  single-cycle error pulse.

Function
REQ-018 Command path SHALL have a one-entry output register; ready to accept = register empty OR (register valid AND its selected intf_cmd_ready_i).
REQ-019 Requester selection SHALL be round-robin: grant the lowest index above the last granted index, wrapping; the pointer advances only on an accepted grant.
REQ-020 A requester whose cmd_id slot is pending SHALL NOT be granted; round-robin skips it.
REQ-021 Accepted command SHALL drive intf_cmd_valid_o[intf_id] in the cycle after acceptance (latency 1) and hold stable until intf_cmd_ready_i.
REQ-022 Command with intf_id >= NUM_INTF SHALL be accepted and dropped, pulse err_o next cycle, pending table unchanged.
REQ-023 Pending table SHALL hold NUM_CLUSTERS*NUM_CORES*NUM_HPU_CMDS (128) entries, indexed by {cluster_id,core_id,local_cmd_id}, each a pending bit plus the generate_event bit.
REQ-024 Pending bit SHALL be set on command acceptance, not on interface handoff.
REQ-025 Completion path SHALL round-robin among intf_resp_valid_i with a one-entry register; acceptance rule as REQ-018 using cmd_resp ready = always 1 (requesters never stall).
REQ-026 On completion acceptance: pending set -> clear it, decrement inflight_o; if stored generate_event=1 assert cmd_resp_valid_o[cluster_id] for exactly one cycle, the cycle after; else drop silently.
REQ-027 Completion for a non-pending slot SHALL be dropped and pulse err_o; inflight_o unchanged.
REQ-028 Same-cycle command accept and completion clear SHALL both take effect; inflight_o net change 0; same-slot set+clear cannot occur (REQ-020 uses pre-clear state).
REQ-029 inflight_o SHALL saturate neither way; it cannot exceed 128 by construction.

Reset
REQ-030 On rst_ni low: all valid outputs, err_o, inflight_o, pending table, RR pointers SHALL reset to 0; cmd_req_ready_o and intf_resp_ready_o SHALL be 0 during reset; in-flight commands are discarded.

Structure
REQ-031 pspin_cmd_t, pspin_cmd_resp_t, pspin_cmd_id_t and sizing constants SHALL come from pspin_cfg_pkg; no new package types.
REQ-032 One sub-module rr_arb_idx (parameterised width, request mask in, grant index out, pointer register) SHALL be instantiated twice.

Verification
REQ-033 Single command cluster 1, core 2, local 3, intf_id=1, generate_event=1 -> intf_cmd_valid_o=3'b010 next cycle; completion on intf 1 -> cmd_resp_valid_o=4'b0010 one cycle, inflight_o 1->0.
REQ-034 All 4 requesters valid continuously, intf ready -> grants 0,1,2,3,0 in successive cycles, throughput 1/cycle.
REQ-035 Requester 0 reissues cmd_id whose slot is pending -> not granted until completion clears slot; requester 2 served meanwhile.
REQ-036 intf_id=3 -> accepted, err_o pulse, no intf valid, inflight_o unchanged; completion for unused cmd_id -> err_o pulse.
REQ-037 generate_event=0 command completes -> no cmd_resp_valid_o, inflight_o decrements.
REQ-038 rst_ni asserted with 5 pending and output register full -> all outputs 0 immediately, inflight_o=0 after release.
